// File: rtl/clock_mode_ctrl.sv
// HH:MM:SS clock for a six-digit 7-segment display, with two-button hour/minute setting.
// The field under edit blinks; the colon blinks in RUN; all display outputs are registered.
module clock_mode_ctrl #(
  parameter int TICK_CYCLES = 100000000
) (
  input  logic        CLK,
  input  logic        RST_BTN,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [1:0]  mode,
  output logic [23:0] bcd,
  output logic [41:0] seg,
  output logic        colon_on,
  output logic        sec_tick
);

  localparam int            PW         = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_CYCLES / 2);
  localparam logic [41:0]   SEG_RESET  = {6{7'h3F}};

  if ((TICK_CYCLES % 2) != 0 || TICK_CYCLES < 4) begin : g_bad_tick
    $error("TICK_CYCLES must be even and at least 4");
  end

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [3:0]    h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
  logic [3:0]    h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
  logic          mode_prev_q, inc_prev_q;

  logic [1:0]    mode_q;
  logic [23:0]   bcd_q;
  logic [41:0]   seg_q, seg_d;
  logic          colon_q, colon_d;

  logic          presc_wrap, half, mode_rise, inc_rise;
  logic [8:0]    s_inc, m_inc;
  logic [7:0]    h_inc;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h6D;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h56;
      4'd5:    seg_of = 7'h5B;
      4'd6:    seg_of = 7'h7B;
      4'd7:    seg_of = 7'h0E;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h5F;
      default: seg_of = 7'h00;
    endcase
  endfunction

  // Returns {carry, tens, ones} for a 00..59 field.
  function automatic logic [8:0] inc_60(input logic [3:0] d1, input logic [3:0] d0);
    if (d0 != 4'd9)      inc_60 = {1'b0, d1, d0 + 4'd1};
    else if (d1 != 4'd5) inc_60 = {1'b0, d1 + 4'd1, 4'd0};
    else                 inc_60 = {1'b1, 4'd0, 4'd0};
  endfunction

  function automatic logic [7:0] inc_24(input logic [3:0] d1, input logic [3:0] d0);
    if (d1 == 4'd2 && d0 == 4'd3) inc_24 = 8'h00;
    else if (d0 == 4'd9)          inc_24 = {d1 + 4'd1, 4'd0};
    else                          inc_24 = {d1, d0 + 4'd1};
  endfunction

  assign presc_wrap = (presc_q == PRESC_LAST);
  assign half       = (presc_q >= PRESC_HALF);
  assign mode_rise  = btn_mode & ~mode_prev_q;
  assign inc_rise   = btn_inc & ~inc_prev_q;
  assign s_inc      = inc_60(s1_q, s0_q);
  assign m_inc      = inc_60(m1_q, m0_q);
  assign h_inc      = inc_24(h1_q, h0_q);

  always_comb begin
    state_d = state_q;
    presc_d = presc_wrap ? '0 : presc_q + PW'(1);
    tick_d  = presc_wrap;
    h1_d    = h1_q;
    h0_d    = h0_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    s1_d    = s1_q;
    s0_d    = s0_q;
    case (state_q)
      ST_RUN: begin
        // A tick coinciding with the mode press still counts before editing starts.
        if (tick_q) begin
          {s1_d, s0_d} = s_inc[7:0];
          if (s_inc[8]) begin
            {m1_d, m0_d} = m_inc[7:0];
            if (m_inc[8]) {h1_d, h0_d} = h_inc;
          end
        end
        if (mode_rise) state_d = ST_SET_HR;
      end
      ST_SET_HR: begin
        if (mode_rise)     state_d = ST_SET_MIN;
        else if (inc_rise) {h1_d, h0_d} = h_inc;
      end
      ST_SET_MIN: begin
        // Leaving the editor restarts the second so the new time starts on a clean boundary.
        if (mode_rise) begin
          state_d = ST_RUN;
          s1_d    = 4'd0;
          s0_d    = 4'd0;
          presc_d = '0;
          tick_d  = 1'b0;
        end else if (inc_rise) begin
          {m1_d, m0_d} = m_inc[7:0];
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    seg_d = {seg_of(h1_q), seg_of(h0_q), seg_of(m1_q), seg_of(m0_q), seg_of(s1_q), seg_of(s0_q)};
    if (state_q == ST_SET_HR && half)  seg_d[41:28] = '0;
    if (state_q == ST_SET_MIN && half) seg_d[27:14] = '0;
  end

  assign colon_d = (state_q == ST_RUN) ? ~half : 1'b1;

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      state_q     <= ST_RUN;
      presc_q     <= '0;
      tick_q      <= 1'b0;
      h1_q        <= 4'd0;
      h0_q        <= 4'd0;
      m1_q        <= 4'd0;
      m0_q        <= 4'd0;
      s1_q        <= 4'd0;
      s0_q        <= 4'd0;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      mode_q      <= 2'd0;
      bcd_q       <= 24'd0;
      seg_q       <= SEG_RESET;
      colon_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      h1_q        <= h1_d;
      h0_q        <= h0_d;
      m1_q        <= m1_d;
      m0_q        <= m0_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      mode_q      <= state_q;
      bcd_q       <= {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q};
      seg_q       <= seg_d;
      colon_q     <= colon_d;
    end
  end

  assign mode     = mode_q;
  assign bcd      = bcd_q;
  assign seg      = seg_q;
  assign colon_on = colon_q;
  assign sec_tick = tick_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl with TICK_CYCLES = 4: directed scenarios plus random button traffic,
// checked against a seconds-of-day reference model.
module tb_clock_mode_ctrl;

  localparam int          TICK     = 4;
  localparam logic [41:0] SEG_ZERO = {6{7'h3F}};

  logic        CLK = 1'b0;
  logic        RST_BTN = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [1:0]  mode;
  logic [23:0] bcd;
  logic [41:0] seg;
  logic        colon_on;
  logic        sec_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time as seconds since midnight.
  int          m_t, m_mode, m_presc;
  bit          m_tick, m_pm, m_pi;
  logic [1:0]  e_mode;
  logic [23:0] e_bcd;
  logic [41:0] e_seg;
  logic        e_colon;

  clock_mode_ctrl #(.TICK_CYCLES(TICK)) dut (
    .CLK(CLK), .RST_BTN(RST_BTN), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .mode(mode), .bcd(bcd), .seg(seg), .colon_on(colon_on), .sec_tick(sec_tick)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] tb_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h6D;  4'd3: return 7'h4F;
      4'd4: return 7'h56;  4'd5: return 7'h5B;  4'd6: return 7'h7B;  4'd7: return 7'h0E;
      4'd8: return 7'h7F;  4'd9: return 7'h5F;  default: return 7'h00;
    endcase
  endfunction

  function automatic logic [23:0] bcd_of(input int t);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_presc = 0; m_tick = 0; m_pm = 0; m_pi = 0;
    e_mode = 2'd0; e_bcd = 24'd0; e_seg = SEG_ZERO; e_colon = 1'b1;
  endtask

  task automatic model_step(input bit bm, input bit bi);
    bit half, mr, ir, tk;
    int h, m;
    logic [23:0] b;
    half = (m_presc >= TICK / 2);
    b = bcd_of(m_t);
    e_mode = 2'(m_mode);
    e_bcd = b;
    e_seg = {tb_seg(b[23:20]), tb_seg(b[19:16]), tb_seg(b[15:12]),
             tb_seg(b[11:8]), tb_seg(b[7:4]), tb_seg(b[3:0])};
    if (m_mode == 1 && half) e_seg[41:28] = '0;
    if (m_mode == 2 && half) e_seg[27:14] = '0;
    e_colon = (m_mode == 0) ? !half : 1'b1;
    mr = bm && !m_pm;
    ir = bi && !m_pi;
    m_pm = bm; m_pi = bi;
    tk = m_tick;
    m_tick = (m_presc == TICK - 1);
    m_presc = (m_presc + 1) % TICK;
    h = m_t / 3600; m = (m_t / 60) % 60;
    case (m_mode)
      0: begin
        if (tk) m_t = (m_t + 1) % 86400;
        if (mr) m_mode = 1;
      end
      1: if (mr) m_mode = 2;
         else if (ir) m_t = ((h + 1) % 24) * 3600 + m * 60 + m_t % 60;
      default: if (mr) begin
                 m_mode = 0; m_t = h * 3600 + m * 60; m_presc = 0; m_tick = 0;
               end else if (ir) m_t = h * 3600 + ((m + 1) % 60) * 60 + m_t % 60;
    endcase
  endtask

  // Called at a falling edge; returns at the next falling edge with the model advanced.
  task automatic cyc(input bit bm, input bit bi);
    btn_mode = bm;
    btn_inc = bi;
    @(posedge CLK);
    if (RST_BTN) model_reset();
    else model_step(bm, bi);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_BTN = 1'b1;
    model_reset();
    cyc(0, 0);
    RST_BTN = 1'b0;
  endtask

  task automatic pulse_mode();
    cyc(1, 0); cyc(0, 0);
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin cyc(0, 1); cyc(0, 0); end
  endtask

  task automatic test_reset();
    #1 RST_BTN = 1'b1;
    model_reset();
    @(negedge CLK);
    n_checks++; if (mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", mode); end
    n_checks++; if (bcd !== 24'd0) begin n_fail++; $display("FAIL reset_bcd: got %h want 000000", bcd); end
    n_checks++; if (seg !== SEG_ZERO) begin n_fail++; $display("FAIL reset_seg: got %h want %h", seg, SEG_ZERO); end
    n_checks++; if (colon_on !== 1'b1) begin n_fail++; $display("FAIL reset_colon: got %b want 1", colon_on); end
    n_checks++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", sec_tick); end
    cyc(0, 0);
    RST_BTN = 1'b0;
  endtask

  task automatic test_first_tick();
    for (int k = 1; k <= TICK; k++) begin
      cyc(0, 0);
      n_checks++;
      if (sec_tick !== (k == TICK)) begin
        n_fail++; $display("FAIL first_tick: cycle %0d got %b want %b", k, sec_tick, (k == TICK));
      end
    end
  endtask

  task automatic test_hour_edit();
    int blanks;
    blanks = 0;
    do_reset();
    pulse_mode();
    for (int i = 0; i < 25; i++) begin
      for (int j = 0; j < 2; j++) begin
        cyc(0, (j == 0));
        n_checks++;
        if (seg !== e_seg) begin
          n_fail++; $display("FAIL hour_edit_seg: got %h want %h", seg, e_seg);
        end
        if (mode == 2'd1 && seg[41:28] == 14'd0) blanks++;
      end
    end
    n_checks++; if (bcd[23:16] !== 8'h01) begin n_fail++; $display("FAIL hour_edit_h: got %h want 01", bcd[23:16]); end
    n_checks++; if (bcd[15:0] !== 16'h0000) begin n_fail++; $display("FAIL hour_edit_ms: got %h want 0000", bcd[15:0]); end
    n_checks++; if (blanks == 0) begin n_fail++; $display("FAIL hour_blink: got %0d blank cycles want >0", blanks); end
  endtask

  task automatic test_simultaneous();
    cyc(1, 1); cyc(0, 0);
    n_checks++; if (mode !== 2'd2) begin n_fail++; $display("FAIL simul_mode: got %0d want 2", mode); end
    n_checks++; if (bcd[23:16] !== 8'h01) begin n_fail++; $display("FAIL simul_h: got %h want 01", bcd[23:16]); end
  endtask

  task automatic test_minute_edit();
    pulse_inc(58);
    n_checks++; if (bcd[15:8] !== 8'h58) begin n_fail++; $display("FAIL min_preset: got %h want 58", bcd[15:8]); end
    pulse_inc(1);
    n_checks++; if (bcd[15:8] !== 8'h59) begin n_fail++; $display("FAIL min_59: got %h want 59", bcd[15:8]); end
    pulse_inc(1);
    n_checks++; if (bcd[23:8] !== 16'h0100) begin n_fail++; $display("FAIL min_wrap: got %h want 0100", bcd[23:8]); end
    pulse_inc(59);
    n_checks++; if (bcd[23:8] !== 16'h0159) begin n_fail++; $display("FAIL min_61: got %h want 0159", bcd[23:8]); end
    cyc(1, 0);
    for (int k = 1; k <= TICK; k++) begin
      cyc(0, 0);
      if (k == 1) begin
        n_checks++;
        if (mode !== 2'd0 || bcd !== 24'h015900) begin
          n_fail++; $display("FAIL min_exit: got mode=%0d bcd=%h want mode=0 bcd=015900", mode, bcd);
        end
      end
      n_checks++;
      if (sec_tick !== (k == TICK)) begin
        n_fail++; $display("FAIL min_exit_presc: cycle %0d tick got %b want %b", k, sec_tick, (k == TICK));
      end
    end
  endtask

  task automatic test_tick_mode();
    int t_before, n;
    logic [23:0] want;
    n = 0;
    while (sec_tick !== 1'b1 && n < 20) begin cyc(0, 0); n++; end
    n_checks++;
    if (sec_tick !== 1'b1) begin
      n_fail++; $display("FAIL tick_mode_wait: got tick=%b want 1 within 20 cycles", sec_tick);
    end
    t_before = m_t;
    want = bcd_of((t_before + 1) % 86400);
    cyc(1, 0); cyc(0, 0);
    n_checks++;
    if (mode !== 2'd1 || bcd !== want) begin
      n_fail++; $display("FAIL tick_mode: got mode=%0d bcd=%h want mode=1 bcd=%h", mode, bcd, want);
    end
    for (int i = 0; i < 12; i++) cyc(0, 0);
    n_checks++;
    if (bcd !== want) begin n_fail++; $display("FAIL set_frozen: got %h want %h", bcd, want); end
    pulse_mode(); pulse_mode();
    for (int i = 0; i < 4; i++) cyc(0, 0);
  endtask

  task automatic test_colon_seg();
    bit c[10];
    int n;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0);
      c[i] = colon_on;
      n_checks++;
      if (colon_on !== e_colon) begin n_fail++; $display("FAIL colon_model: got %b want %b", colon_on, e_colon); end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (c[i + 2] !== !c[i]) begin
        n_fail++; $display("FAIL colon_toggle: sample %0d got %b want %b", i + 2, c[i + 2], !c[i]);
      end
    end
    n = 0;
    while (bcd[3:0] !== 4'd7 && n < 200) begin cyc(0, 0); n++; end
    n_checks++;
    if (bcd[3:0] !== 4'd7 || seg[6:0] !== 7'h0E) begin
      n_fail++; $display("FAIL seg_seven: got s0=%h seg=%h want s0=7 seg=0e", bcd[3:0], seg[6:0]);
    end
  endtask

  task automatic test_rollover();
    bit saw_max, saw_wrap;
    saw_max = 0; saw_wrap = 0;
    do_reset();
    pulse_mode();
    pulse_inc(23);
    pulse_mode();
    pulse_inc(59);
    cyc(1, 0);
    for (int i = 0; i < 400 && !saw_wrap; i++) begin
      cyc(0, 0);
      n_checks++;
      if (bcd !== e_bcd) begin n_fail++; $display("FAIL rollover_bcd: got %h want %h", bcd, e_bcd); end
      if (bcd == 24'h235959) saw_max = 1;
      else if (saw_max && bcd == 24'h000000) begin
        saw_wrap = 1;
        n_checks++;
        if (seg !== SEG_ZERO) begin n_fail++; $display("FAIL rollover_seg: got %h want %h", seg, SEG_ZERO); end
      end
    end
    n_checks++;
    if (!saw_wrap) begin n_fail++; $display("FAIL rollover_wrap: got max=%b wrap=%b want both 1", saw_max, saw_wrap); end
  endtask

  task automatic test_reset_mid_edit();
    int m;
    pulse_mode(); pulse_mode();
    m = (m_t / 60) % 60;
    pulse_inc((37 - m + 60) % 60);
    n_checks++;
    if (mode !== 2'd2 || bcd[15:8] !== 8'h37) begin
      n_fail++; $display("FAIL mid_edit_setup: got mode=%0d m=%h want mode=2 m=37", mode, bcd[15:8]);
    end
    RST_BTN = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (mode !== 2'd0 || bcd !== 24'd0 || seg !== SEG_ZERO) begin
      n_fail++; $display("FAIL mid_edit_reset: got mode=%0d bcd=%h seg=%h want 0 000000 %h", mode, bcd, seg, SEG_ZERO);
    end
    cyc(0, 0);
    RST_BTN = 1'b0;
    cyc(0, 0); cyc(0, 0);
    n_checks++;
    if (mode !== 2'd0 || bcd !== 24'd0) begin
      n_fail++; $display("FAIL mid_edit_after: got mode=%0d bcd=%h want 0 000000", mode, bcd);
    end
  endtask

  task automatic test_random();
    bit bm, bi;
    for (int i = 0; i < 3000; i++) begin
      bm = ($urandom_range(0, 15) == 0);
      bi = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 999) == 0) begin
        RST_BTN = 1'b1;
        model_reset();
      end
      cyc(bm, bi);
      RST_BTN = 1'b0;
      n_checks++;
      if (mode !== e_mode || bcd !== e_bcd || seg !== e_seg || colon_on !== e_colon || sec_tick !== m_tick) begin
        n_fail++;
        $display("FAIL random cyc %0d: got mode=%0d bcd=%h seg=%h colon=%b tick=%b want mode=%0d bcd=%h seg=%h colon=%b tick=%b",
                 i, mode, bcd, seg, colon_on, sec_tick, e_mode, e_bcd, e_seg, e_colon, m_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_hour_edit();
    test_simultaneous();
    test_minute_edit();
    test_tick_mode();
    test_colon_seg();
    test_rollover();
    test_reset_mid_edit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100000000, meaning CLK cycles per second; it SHALL be legal only if even and >= 4.
REQ-002 SHALL have port CLK  input  1  board clock, with all state updated on its rising edge.
REQ-003 SHALL have port RST_BTN  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port btn_mode  input  1  synchronous, debounced level; a rising edge advances the mode.
REQ-005 SHALL have port btn_inc  input  1  synchronous, debounced level; a rising edge increments the field being edited.
REQ-006 SHALL have port mode  output  2  current mode: 0 = RUN, 1 = SET_HR, 2 = SET_MIN.
REQ-007 SHALL have port bcd  output  24  {h1,h0,m1,m0,s1,s0}, 4 bits each, with h1 in bits [23:20].
REQ-008 SHALL have port seg  output  42  six 7-bit segment masks in the same digit order as bcd, with h1 in bits [41:35].
REQ-009 SHALL have port colon_on  output  1  enable for the four colon dots.
REQ-010 SHALL have port sec_tick  output  1  one-cycle pulse when the prescaler wraps.

Function
REQ-011 SHALL keep a prescaler counting 0..TICK_CYCLES-1, and SHALL assert sec_tick in the cycle it wraps to 0.
REQ-012 SHALL define half = 1 while prescaler >= TICK_CYCLES/2, else 0.
REQ-013 SHALL detect rising edges as input high now and low in the previous cycle; the previous-value registers reset to 0.
REQ-014 SHALL implement FSM RUN -> SET_HR -> SET_MIN -> RUN, advancing one step per btn_mode edge.
REQ-015 SHALL, in RUN, on sec_tick, count s 59->00 with carry to m, m 59->00 with carry to h, and h 23->00 (23:59:59 -> 00:00:00).
REQ-016 SHALL, in SET_HR, on a btn_inc edge, increment h 23->00, with no carry and no change to m or s.
REQ-017 SHALL, in SET_MIN, on a btn_inc edge, increment m 59->00, with no carry to h.
REQ-018 SHALL, in both SET modes, keep the prescaler running and ignore sec_tick for the time count, so s is frozen.
REQ-019 SHALL, on the SET_MIN->RUN transition, clear s to 00 and the prescaler to 0 in the same cycle.
REQ-020 SHALL, on a btn_mode edge and a btn_inc edge in the same cycle, apply the mode change and drop the inc.
REQ-021 SHALL, on a RUN->SET_HR edge coinciding with sec_tick, apply the tick before entering SET_HR.
REQ-022 SHALL ignore btn_inc in RUN.
REQ-023 SHALL store time as BCD digits, with h1 in 0..2, h0 in 0..9, and m1/s1 in 0..5; an invalid digit value SHALL never be reachable.
REQ-024 SHALL use segment bit numbering 0 = bottom, 1 = lower right, 2 = upper right, 3 = top, 4 = upper left, 5 = lower left, 6 = middle.
REQ-025 SHALL encode digits 0-9 as 3F, 06, 6D, 4F, 56, 5B, 7B, 0E, 7F, 5F (hex).
REQ-026 SHALL force the h1/h0 masks to 00 while mode = SET_HR and half = 1.
REQ-027 SHALL force the m1/m0 masks to 00 while mode = SET_MIN and half = 1.
REQ-028 SHALL drive colon_on = ~half in RUN, and colon_on = 1 in both SET modes.
REQ-029 SHALL register mode, bcd, seg and colon_on, each reflecting internal state with exactly 1 cycle latency.

Reset
REQ-030 SHALL, while RST_BTN = 1, immediately force time 00:00:00, mode = RUN, prescaler = 0, and edge registers = 0.
REQ-031 SHALL, while RST_BTN = 1, immediately force bcd = 0, every seg digit = 3F, colon_on = 1, and sec_tick = 0.
REQ-032 SHALL, on reset asserted mid-edit, abandon the edit, so the pre-reset hour or minute value is not retained.
REQ-033 SHALL, after RST_BTN deasserts, emit the first sec_tick TICK_CYCLES cycles later.

Verification (TICK_CYCLES = 4)
REQ-034 SHALL cover rollover: preload to 23:59:59 via the SET modes and run one tick -> bcd = 000000, seg = all 3F.
REQ-035 SHALL cover hour edit: enter SET_HR and pulse btn_inc 25 times -> h = 01 with m unchanged, and h masks = 00 in cycles where half = 1.
REQ-036 SHALL cover minute edit: in SET_MIN, pulse btn_inc 61 times from m = 58 -> m = 59 then 00, h unchanged; leaving to RUN -> s = 00, prescaler = 0, mode = 0.
REQ-037 SHALL cover simultaneous edges: btn_mode and btn_inc rise together in SET_HR -> mode = 2, h unchanged.
REQ-038 SHALL cover colon and segments: in RUN -> colon_on toggles every 2 cycles, and digit 7 in s0 -> seg[6:0] = 0E.
REQ-039 SHALL cover reset mid-edit: assert RST_BTN for 1 cycle in SET_MIN with m = 37 -> mode = 0, bcd = 0 immediately.
